alu_writeback_stage: RTL and testbench
======================================

// Module: alu_writeback_stage
// PURPOSE
//  Pipeline stage directly downstream of the ALU: captures result bus and NZCV
//  flags, buffers them in a 2-entry skid buffer with valid/ready handshake,
//  retires them to the register-file write port and the architectural flags
//  register. Decouples combinational ALU timing from register-file stalls.
// PARAMETERS
//  BITS      3  datapath width; must equal the ALU BITS
//  ADDR_BITS 4  destination-register address width (16 registers)
// PORTS
//  clk_i          in   1          system clock, rising edge
//  rst_n_i        in   1          asynchronous active-low reset
//  valid_i        in   1          ALU result valid
//  ready_o        out  1          stage can accept an entry
//  result_i       in   BITS       ALU result bus
//  flags_i        in   4          ALU flags {N,Z,C,V}
//  rd_i           in   ADDR_BITS  destination register
//  wr_en_i        in   1          result is written to rd
//  set_flags_i    in   1          entry updates architectural flags
//  valid_o        out  1          head entry valid
//  ready_i        in   1          register file accepts head entry
//  wb_data_o      out  BITS       head entry result
//  wb_addr_o      out  ADDR_BITS  head entry destination
//  wb_we_o        out  1          valid_o & ready_i & head.wr_en
//  flags_o        out  4          architectural NZCV register
// BEHAVIOUR
//  - Reset: buffer EMPTY, valid_o=0, ready_o=1, wb_data_o/wb_addr_o=0,
//    wb_we_o=0, flags_o=4'b0000. Reset asserted mid-operation drops all entries.
//  - Accept = valid_i & ready_o; retire = valid_o & ready_i; both on clk edge.
//  - States EMPTY(0), ONE(1), FULL(2) entries, 2-bit count:
//    EMPTY: accept -> ONE.  ONE: accept&~retire -> FULL, retire&~accept -> EMPTY,
//    both or neither -> ONE.  FULL: retire -> ONE (no accept possible).
//  - ready_o = (state != FULL), from registered state only; no comb path from
//    ready_i to ready_o. valid_o = (state != EMPTY).
//  - Latency: accepted entry appears on valid_o the next cycle; throughput
//    1 entry/cycle when ready_i held high. Strict FIFO order.
//  - Head/tail pointers 1 bit, wrap 1->0. Simultaneous accept+retire in ONE:
//    head advances, new entry written at tail, count unchanged.
//  - Flags: on retire with head.set_flags=1, flags_o <= head.flags next cycle;
//    set_flags=0 leaves flags_o unchanged. Flags commit at retire, not accept.
//  - valid_i with ready_o=0: no capture; upstream must hold inputs stable.
//  - No arithmetic on data; result/flags stored bit-exact.
// CONFIGURATION
//  WB_RETIRE_COUNT_EN defined: adds port retire_count_o out 16, counting
//    retires; reset 0, wraps 16'hFFFF->16'h0000; increments on same edge as retire.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package alu_pkg: typedef flags_t {n,z,c,v}; localparams FLAG_N/Z/C/V bit
//    indices; typedef struct wb_entry_t {result, flags, rd, wr_en, set_flags}.
//  Sub-module wb_skid_buffer (2-entry FIFO of wb_entry_t with count/pointers);
//    top adds flags register, wb_we_o logic and optional counter.
// TESTING
//  1 Reset: rst_n_i=0 mid-stream -> valid_o=0, ready_o=1, flags_o=0, count=0.
//  2 Stream: ready_i=1, 3 entries result 3'b101,3'b010,3'b111 rd 1,2,3 ->
//    wb_data_o same order, one cycle after each accept, wb_we_o each cycle.
//  3 Backpressure: ready_i=0, push 3 entries -> ready_o=0 after 2nd; release
//    ready_i -> entries 1,2 retire in order, 3rd then accepted.
//  4 Flags: entry flags 4'b1010 set_flags=1, next flags 4'b0101 set_flags=0
//    -> flags_o=4'b1010 after first retire, unchanged after second.
//  5 ONE state, valid_i=1 & ready_i=1 simultaneously -> count stays 1, order kept.
//  6 WB_RETIRE_COUNT_EN: preload 16'hFFFF retires -> next retire gives 16'h0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback stage: NZCV flag layout, buffered entry and buffer states.
package alu_pkg;

    localparam int WB_BITS      = 3;
    localparam int WB_ADDR_BITS = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic [WB_BITS-1:0]      result;
        flags_t                  flags;
        logic [WB_ADDR_BITS-1:0] rd;
        logic                    wr_en;
        logic                    set_flags;
    } wb_entry_t;

    // Encoding equals the number of entries held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } wb_state_t;

    function automatic flags_t to_flags(input logic [3:0] raw);
        flags_t f;
        f.n = raw[FLAG_N];
        f.z = raw[FLAG_Z];
        f.c = raw[FLAG_C];
        f.v = raw[FLAG_V];
        return f;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU-side and register-file-side handshake bundle of the writeback stage.
// retire_count_o exists only when WB_RETIRE_COUNT_EN is defined.
interface alu_writeback_stage_if #(
    parameter int BITS      = 3,
    parameter int ADDR_BITS = 4
);
    logic                 valid_i;
    logic                 ready_o;
    logic [BITS-1:0]      result_i;
    logic [3:0]           flags_i;
    logic [ADDR_BITS-1:0] rd_i;
    logic                 wr_en_i;
    logic                 set_flags_i;

    logic                 valid_o;
    logic                 ready_i;
    logic [BITS-1:0]      wb_data_o;
    logic [ADDR_BITS-1:0] wb_addr_o;
    logic                 wb_we_o;
    logic [3:0]           flags_o;
`ifdef WB_RETIRE_COUNT_EN
    logic [15:0]          retire_count_o;
`endif

    modport slave (
        input  valid_i, result_i, flags_i, rd_i, wr_en_i, set_flags_i, ready_i,
        output ready_o, valid_o, wb_data_o, wb_addr_o, wb_we_o, flags_o
`ifdef WB_RETIRE_COUNT_EN
        , output retire_count_o
`endif
    );

    modport master (
        output valid_i, result_i, flags_i, rd_i, wr_en_i, set_flags_i, ready_i,
        input  ready_o, valid_o, wb_data_o, wb_addr_o, wb_we_o, flags_o
`ifdef WB_RETIRE_COUNT_EN
        , input retire_count_o
`endif
    );

endinterface

// File: rtl/wb_skid_buffer.sv
// Two-entry FIFO of writeback entries; the state register doubles as the occupancy count,
// so ready/valid decode only from registered state.
module wb_skid_buffer
    import alu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      push_valid_i,
    output logic      push_ready_o,
    input  wb_entry_t push_entry_i,
    output logic      pop_valid_o,
    input  logic      pop_ready_i,
    output wb_entry_t pop_entry_o
);

    wb_state_t r_state;
    wb_state_t w_state_nxt;
    wb_entry_t r_mem [2];
    logic      r_head;
    logic      r_tail;
    logic      w_push;
    logic      w_pop;

    assign push_ready_o = (r_state != ST_FULL);
    assign pop_valid_o  = (r_state != ST_EMPTY);
    assign w_push       = push_valid_i & push_ready_o;
    assign w_pop        = pop_valid_o & pop_ready_i;
    assign pop_entry_o  = r_mem[r_head];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = ST_FULL;
                end else if (w_pop && !w_push) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero until the first accept.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= push_entry_i;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: skid-buffers ALU results and retires them to the register file and
// the architectural NZCV register. Define WB_RETIRE_COUNT_EN to add a 16-bit retire counter.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int BITS      = WB_BITS,
    parameter int ADDR_BITS = WB_ADDR_BITS
)
(
    input logic                  clk_i,
    input logic                  rst_n_i,
    alu_writeback_stage_if.slave bus
);

    wb_entry_t            w_in_entry;
    wb_entry_t            w_head;
    logic                 w_head_valid;
    logic                 w_ready;
    logic                 w_retire;
    logic [BITS-1:0]      w_head_data;
    logic [ADDR_BITS-1:0] w_head_addr;
    flags_t               r_flags;

    always_comb begin
        w_in_entry           = '0;
        w_in_entry.result    = bus.result_i;
        w_in_entry.flags     = to_flags(bus.flags_i);
        w_in_entry.rd        = bus.rd_i;
        w_in_entry.wr_en     = bus.wr_en_i;
        w_in_entry.set_flags = bus.set_flags_i;
    end

    wb_skid_buffer u_skid (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .push_valid_i (bus.valid_i),
        .push_ready_o (w_ready),
        .push_entry_i (w_in_entry),
        .pop_valid_o  (w_head_valid),
        .pop_ready_i  (bus.ready_i),
        .pop_entry_o  (w_head)
    );

    assign w_retire    = w_head_valid & bus.ready_i;
    assign w_head_data = w_head.result;
    assign w_head_addr = w_head.rd;

    assign bus.ready_o   = w_ready;
    assign bus.valid_o   = w_head_valid;
    assign bus.wb_data_o = w_head_data;
    assign bus.wb_addr_o = w_head_addr;
    assign bus.wb_we_o   = w_retire & w_head.wr_en;
    assign bus.flags_o   = r_flags;

    // Flags commit when the entry retires, never when it is accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_flags <= '0;
        end else if (w_retire && w_head.set_flags) begin
            r_flags <= w_head.flags;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [15:0] r_retire_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_retire_count <= 16'h0000;
        end else if (w_retire) begin
            r_retire_count <= r_retire_count + 16'd1;
        end
    end

    assign bus.retire_count_o = r_retire_count;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: a queue-based model predicts accepts and retires,
// and a negedge monitor compares every presented head entry and the flag register.
module tb_alu_writeback_stage;
    import alu_pkg::*;

    logic clk_i = 1'b0;
    logic rst_n_i;

    always #5 clk_i = ~clk_i;

    alu_writeback_stage_if #(.BITS(3), .ADDR_BITS(4)) bus ();

    alu_writeback_stage #(.BITS(3), .ADDR_BITS(4)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0] res;
        logic [3:0] fl;
        logic [3:0] rd;
        logic       we;
        logic       sf;
    } exp_t;

    exp_t        sb_q[$];
    int          m_occ     = 0;
    logic        m_acc     = 1'b0;
    logic [3:0]  m_flags   = 4'h0;
    logic [15:0] m_retires = 16'h0000;
    int          tests     = 0;
    int          fails     = 0;
    logic        m_acc_now;
    logic        m_ret_now;

    assign m_acc_now = bus.valid_i && (m_occ < 2);
    assign m_ret_now = (m_occ > 0) && bus.ready_i;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the two-deep queue: an accept needs fewer than two entries held.
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_occ <= 0;
            m_acc <= 1'b0;
            sb_q.delete();
        end else begin
            if (m_acc_now) begin
                sb_q.push_back('{bus.result_i, bus.flags_i, bus.rd_i, bus.wr_en_i, bus.set_flags_i});
            end
            m_acc <= m_acc_now;
            m_occ <= m_occ + (m_acc_now ? 1 : 0) - (m_ret_now ? 1 : 0);
        end
    end

    // Monitor: compares the head entry and status outputs mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            check("rst_valid_o", {15'd0, bus.valid_o}, 16'd0);
            check("rst_ready_o", {15'd0, bus.ready_o}, 16'd1);
            check("rst_flags_o", {12'd0, bus.flags_o}, 16'd0);
            check("rst_wb_data_o", {13'd0, bus.wb_data_o}, 16'd0);
            check("rst_wb_addr_o", {12'd0, bus.wb_addr_o}, 16'd0);
            check("rst_wb_we_o", {15'd0, bus.wb_we_o}, 16'd0);
`ifdef WB_RETIRE_COUNT_EN
            check("rst_retire_count", bus.retire_count_o, 16'd0);
`endif
            m_flags   <= 4'h0;
            m_retires <= 16'h0000;
        end else begin
            check("ready_o", {15'd0, bus.ready_o}, {15'd0, (m_occ < 2)});
            check("valid_o", {15'd0, bus.valid_o}, {15'd0, (m_occ > 0)});
            check("flags_o", {12'd0, bus.flags_o}, {12'd0, m_flags});
`ifdef WB_RETIRE_COUNT_EN
            check("retire_count", bus.retire_count_o, m_retires);
`endif
            if (m_occ > 0 && sb_q.size() > 0) begin
                check("wb_data_o", {13'd0, bus.wb_data_o}, {13'd0, sb_q[0].res});
                check("wb_addr_o", {12'd0, bus.wb_addr_o}, {12'd0, sb_q[0].rd});
                if (bus.ready_i) begin
                    check("wb_we_o", {15'd0, bus.wb_we_o}, {15'd0, sb_q[0].we});
                    if (sb_q[0].sf) begin
                        m_flags <= sb_q[0].fl;
                    end
                    m_retires <= m_retires + 16'd1;
                    void'(sb_q.pop_front());
                end else begin
                    check("wb_we_stalled", {15'd0, bus.wb_we_o}, 16'd0);
                end
            end else begin
                check("wb_we_idle", {15'd0, bus.wb_we_o}, 16'd0);
            end
        end
    end

    task automatic send(input logic [2:0] res, input logic [3:0] fl, input logic [3:0] rd,
                        input logic we, input logic sf);
        int n;
        n = 0;
        bus.valid_i     = 1'b1;
        bus.result_i    = res;
        bus.flags_i     = fl;
        bus.rd_i        = rd;
        bus.wr_en_i     = we;
        bus.set_flags_i = sf;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!m_acc && n < 20);
        if (!m_acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: rd=%0d not accepted after %0d cycles", rd, n);
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        bus.valid_i     = 1'b0;
        bus.result_i    = 3'd0;
        bus.flags_i     = 4'd0;
        bus.rd_i        = 4'd0;
        bus.wr_en_i     = 1'b0;
        bus.set_flags_i = 1'b0;
        bus.ready_i     = 1'b0;
        rst_n_i         = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Back-to-back stream with the register file always ready.
        bus.ready_i = 1'b1;
        send(3'b101, 4'h0, 4'd1, 1'b1, 1'b0);
        send(3'b010, 4'h0, 4'd2, 1'b1, 1'b0);
        send(3'b111, 4'h0, 4'd3, 1'b1, 1'b0);
        idle(3);

        // Backpressure: two entries fill the buffer, the third waits.
        bus.ready_i = 1'b0;
        send(3'b011, 4'h0, 4'd4, 1'b1, 1'b0);
        send(3'b100, 4'h0, 4'd5, 1'b0, 1'b0);
        bus.valid_i  = 1'b1;
        bus.result_i = 3'b110;
        bus.rd_i     = 4'd6;
        bus.wr_en_i  = 1'b1;
        idle(0);
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        check("bp_ready_low", {15'd0, bus.ready_o}, 16'd0);
        bus.ready_i = 1'b1;
        send(3'b110, 4'h0, 4'd6, 1'b1, 1'b0);
        idle(4);

        // Flags commit at retire, and set_flags=0 leaves them alone.
        bus.ready_i = 1'b0;
        send(3'b001, 4'b1010, 4'd7, 1'b1, 1'b1);
        idle(2);
        check("flags_not_at_accept", {12'd0, bus.flags_o}, 16'h0000);
        bus.ready_i = 1'b1;
        idle(2);
        check("flags_after_retire", {12'd0, bus.flags_o}, 16'h000A);
        send(3'b110, 4'b0101, 4'd8, 1'b0, 1'b0);
        idle(3);
        check("flags_unchanged", {12'd0, bus.flags_o}, 16'h000A);

        // Simultaneous accept and retire with one entry held.
        bus.ready_i = 1'b0;
        send(3'b010, 4'h3, 4'd9, 1'b1, 1'b0);
        bus.ready_i = 1'b1;
        send(3'b101, 4'h6, 4'd10, 1'b1, 1'b1);
        check("one_state_valid", {15'd0, bus.valid_o}, 16'd1);
        check("one_state_ready", {15'd0, bus.ready_o}, 16'd1);
        idle(3);

        // Randomized traffic; a refused entry is held stable until taken.
        for (int i = 0; i < 400; i++) begin
            if (!bus.valid_i || m_acc) begin
                bus.valid_i     = ($urandom_range(0, 9) < 7);
                bus.result_i    = 3'($urandom);
                bus.flags_i     = 4'($urandom);
                bus.rd_i        = 4'($urandom);
                bus.wr_en_i     = 1'($urandom);
                bus.set_flags_i = 1'($urandom);
            end
            bus.ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk_i);
            #1;
        end
        bus.ready_i = 1'b1;
        idle(4);

        // Reset in the middle of a full buffer.
        bus.ready_i = 1'b0;
        send(3'b111, 4'hF, 4'd11, 1'b1, 1'b1);
        send(3'b011, 4'h9, 4'd12, 1'b1, 1'b1);
        bus.valid_i = 1'b1;
        rst_n_i     = 1'b0;
        #2;
        check("mid_rst_valid_o", {15'd0, bus.valid_o}, 16'd0);
        check("mid_rst_ready_o", {15'd0, bus.ready_o}, 16'd1);
        check("mid_rst_flags_o", {12'd0, bus.flags_o}, 16'd0);
        bus.valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

`ifdef WB_RETIRE_COUNT_EN
        bus.ready_i = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            send(3'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
        end
        idle(2);
        check("retire_count_preload", bus.retire_count_o, 16'hFFFF);
        send(3'b001, 4'h0, 4'd1, 1'b1, 1'b0);
        idle(2);
        check("retire_count_wrap", bus.retire_count_o, 16'h0000);
`endif

        // Stream after reset to confirm clean restart.
        bus.ready_i = 1'b1;
        send(3'b100, 4'b1100, 4'd13, 1'b1, 1'b1);
        send(3'b001, 4'b0011, 4'd14, 1'b1, 1'b0);
        idle(3);
        check("post_rst_flags", {12'd0, bus.flags_o}, 16'h000C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
